// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, trap/jump redirects,
// sequential stepping (2 or 4 bytes) and a count of PCs accepted by fetch.
module pc_gen #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
    parameter bit              C_EXT     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            trap_en_i,
    input  logic [XLEN-1:0] trap_addr_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            len16_i,
    input  logic            pc_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            halted_o,
    output logic [XLEN-1:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] cnt_q, cnt_nxt;
    logic            halted_q;
    logic            fire;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] mask;
        mask = C_EXT ? ~XLEN'(1) : ~XLEN'(3);
        return addr & mask;
    endfunction

    function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] pc,
                                                 input logic            is16);
        return pc + ((C_EXT && is16) ? XLEN'(2) : XLEN'(4));
    endfunction

    assign pc_valid_o = (state == RUN) && !stall_i;
    assign fire       = pc_valid_o && pc_ready_i;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        // An accepted offer is always counted, even when a redirect wins the PC.
        cnt_nxt   = fire ? cnt_q + XLEN'(1) : cnt_q;
        if (trap_en_i) begin
            pc_nxt    = align_target(trap_addr_i);
            state_nxt = RUN;
        end else begin
            case (state)
                BOOT: state_nxt = RUN;
                RUN: begin
                    if (jump_en_i) begin
                        pc_nxt = align_target(jump_addr_i);
                    end else begin
                        if (fire)   pc_nxt    = seq_next(pc_q, len16_i);
                        if (halt_i) state_nxt = HALT;
                    end
                end
                HALT: state_nxt = HALT;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc_q     <= RESET_VEC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            cnt_q    <= cnt_nxt;
            halted_q <= (state_nxt == HALT);
        end
    end

    assign pc_o        = pc_q;
    assign fetch_cnt_o = cnt_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: four configurations share one stimulus stream,
// each expectation names which instance it targets.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tr = 1'b0, jp = 1'b0, st = 1'b0, ht = 1'b0, l16 = 1'b0, rdy = 1'b0;
    logic [63:0] ta = '0, ja = '0;

    logic [63:0] pc0, cnt0, pc1, cnt1;
    logic [31:0] pc2, cnt2;
    logic [7:0]  pc3, cnt3;
    logic        v0, h0, v1, h1, v2, h2, v3, h3;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(64), .C_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .jump_en_i(jp), .jump_addr_i(ja), .trap_en_i(tr),
        .trap_addr_i(ta), .stall_i(st), .halt_i(ht), .len16_i(l16), .pc_ready_i(rdy),
        .pc_o(pc0), .pc_valid_o(v0), .halted_o(h0), .fetch_cnt_o(cnt0));

    pc_gen #(.XLEN(64), .C_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .jump_en_i(jp), .jump_addr_i(ja), .trap_en_i(tr),
        .trap_addr_i(ta), .stall_i(st), .halt_i(ht), .len16_i(l16), .pc_ready_i(rdy),
        .pc_o(pc1), .pc_valid_o(v1), .halted_o(h1), .fetch_cnt_o(cnt1));

    pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFF8), .C_EXT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .jump_en_i(jp), .jump_addr_i(ja[31:0]), .trap_en_i(tr),
        .trap_addr_i(ta[31:0]), .stall_i(st), .halt_i(ht), .len16_i(l16), .pc_ready_i(rdy),
        .pc_o(pc2), .pc_valid_o(v2), .halted_o(h2), .fetch_cnt_o(cnt2));

    pc_gen #(.XLEN(8), .RESET_VEC(8'h00), .C_EXT(1'b0)) dut3 (
        .clk(clk), .rst(rst), .jump_en_i(jp), .jump_addr_i(ja[7:0]), .trap_en_i(tr),
        .trap_addr_i(ta[7:0]), .stall_i(st), .halt_i(ht), .len16_i(l16), .pc_ready_i(rdy),
        .pc_o(pc3), .pc_valid_o(v3), .halted_o(h3), .fetch_cnt_o(cnt3));

    typedef struct packed {
        logic [1:0]  sel;
        logic [63:0] pc;
        logic        v;
        logic        h;
        logic [63:0] cnt;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad   = 0;

    exp_t        e;
    string       nm;
    logic [63:0] apc, acnt;
    logic        av, ah;

    // Monitor: compares the outputs seen mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            case (e.sel)
                2'd0: begin apc = pc0;       av = v0; ah = h0; acnt = cnt0;       end
                2'd1: begin apc = pc1;       av = v1; ah = h1; acnt = cnt1;       end
                2'd2: begin apc = 64'(pc2);  av = v2; ah = h2; acnt = 64'(cnt2);  end
                default: begin apc = 64'(pc3); av = v3; ah = h3; acnt = 64'(cnt3); end
            endcase
            total++;
            if (apc !== e.pc || av !== e.v || ah !== e.h || acnt !== e.cnt) begin
                bad++;
                $display("FAIL %s: got pc=%h valid=%b halted=%b cnt=%h, want pc=%h valid=%b halted=%b cnt=%h",
                         nm, apc, av, ah, acnt, e.pc, e.v, e.h, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] sel, input logic [63:0] pc, input logic v,
                            input logic h, input logic [63:0] cnt, input string name);
        exp_t x;
        x.sel = sel; x.pc = pc; x.v = v; x.h = h; x.cnt = cnt;
        q.push_back(x);
        nq.push_back(name);
    endtask

    initial begin
        // Config 0: XLEN=64, C_EXT=0
        tick(); rst = 1'b1;             push_exp(0, 64'h8000_0000, 0, 0, 0, "reset_state");
        tick(); rst = 1'b0; rdy = 1'b1; push_exp(0, 64'h8000_0000, 0, 0, 0, "boot_cycle");
        tick();                         push_exp(0, 64'h8000_0000, 1, 0, 0, "run_first");
        tick();                         push_exp(0, 64'h8000_0004, 1, 0, 1, "run_seq1");
        tick();                         push_exp(0, 64'h8000_0008, 1, 0, 2, "run_seq2");
        tick(); rdy = 1'b0;             push_exp(0, 64'h8000_000C, 1, 0, 3, "not_ready0");
        tick();                         push_exp(0, 64'h8000_000C, 1, 0, 3, "not_ready1");
        tick();                         push_exp(0, 64'h8000_000C, 1, 0, 3, "not_ready2");
        tick(); rdy = 1'b1; st = 1'b1;  push_exp(0, 64'h8000_000C, 0, 0, 3, "stall0");
        tick();                         push_exp(0, 64'h8000_000C, 0, 0, 3, "stall1");
        tick(); st = 1'b0;              push_exp(0, 64'h8000_000C, 1, 0, 3, "unstall");
        tick(); rdy = 1'b0; jp = 1'b1; ja = 64'h8000_1003; tr = 1'b1; ta = 64'h8000_2000;
                                        push_exp(0, 64'h8000_0010, 1, 0, 4, "after_unstall");
        tick(); tr = 1'b0; rdy = 1'b1;  push_exp(0, 64'h8000_2000, 1, 0, 4, "trap_over_jump");
        tick(); jp = 1'b0; rdy = 1'b0;  push_exp(0, 64'h8000_1000, 1, 0, 5, "jump_fire_counts");
        tick(); ht = 1'b1; rdy = 1'b1;  push_exp(0, 64'h8000_1000, 1, 0, 5, "halt_req");
        tick(); ht = 1'b0; jp = 1'b1; ja = 64'h8000_3000;
                                        push_exp(0, 64'h8000_1004, 0, 1, 6, "halted_fire_adv");
        tick(); jp = 1'b0; tr = 1'b1; ta = 64'h8000_0100;
                                        push_exp(0, 64'h8000_1004, 0, 1, 6, "halt_ignores_jump");
        tick(); tr = 1'b0; rdy = 1'b0;  push_exp(0, 64'h8000_0100, 1, 0, 6, "trap_leaves_halt");
        tick(); rst = 1'b1; tr = 1'b1; ta = 64'h8000_0200; rdy = 1'b1;
                                        push_exp(0, 64'h8000_0100, 1, 0, 6, "pre_reset");
        tick(); rst = 1'b0;             push_exp(0, 64'h8000_0000, 0, 0, 0, "reset_beats_trap");
        tick(); tr = 1'b0;              push_exp(0, 64'h8000_0200, 1, 0, 0, "trap_in_boot");
        tick(); rdy = 1'b0;             push_exp(0, 64'h8000_0204, 1, 0, 1, "after_boot_trap");
        tick(); ht = 1'b1;              push_exp(0, 64'h8000_0204, 1, 0, 1, "halt_no_fire");
        tick(); ht = 1'b0; rst = 1'b1;  push_exp(0, 64'h8000_0204, 0, 1, 1, "halted_hold");
        tick(); rst = 1'b0;             push_exp(0, 64'h8000_0000, 0, 0, 0, "reset_from_halt");

        // Config 1: C_EXT=1
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; rdy = 1'b0; push_exp(1, 64'h8000_0000, 0, 0, 0, "c_boot");
        tick(); rdy = 1'b1; l16 = 1'b1; push_exp(1, 64'h8000_0000, 1, 0, 0, "c_start");
        tick(); l16 = 1'b0;             push_exp(1, 64'h8000_0002, 1, 0, 1, "c_step2");
        tick(); rdy = 1'b0;             push_exp(1, 64'h8000_0006, 1, 0, 2, "c_step4");
        tick(); jp = 1'b1; ja = 64'h8000_1003;
                                        push_exp(1, 64'h8000_0006, 1, 0, 2, "c_hold");
        tick(); jp = 1'b0; tr = 1'b1; ta = 64'h8000_2001;
                                        push_exp(1, 64'h8000_1002, 1, 0, 2, "c_jump_align");
        tick(); tr = 1'b0;              push_exp(1, 64'h8000_2000, 1, 0, 2, "c_trap_align");

        // Config 2: XLEN=32 PC wrap
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; rdy = 1'b1; push_exp(2, 64'hFFFF_FFF8, 0, 0, 0, "w_boot");
        tick();                         push_exp(2, 64'hFFFF_FFF8, 1, 0, 0, "w_pc0");
        tick();                         push_exp(2, 64'hFFFF_FFFC, 1, 0, 1, "w_pc1");
        tick();                         push_exp(2, 64'h0000_0000, 1, 0, 2, "w_pc_wrap");
        tick(); rdy = 1'b0;             push_exp(2, 64'h0000_0004, 1, 0, 3, "w_pc_after");

        // Config 3: XLEN=8, counter and PC wrap through all-ones
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 258; i++) begin
            tick();
            push_exp(3, 64'((4 * i) % 256), 1, 0, 64'(i % 256), "cnt_wrap");
        end
        rdy = 1'b0;

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
